// File: rtl/ws2812_stream_decoder.sv
// WS2812-style single-wire stream decoder: measures symbol high times, assembles
// 24-bit GRB pixels MSB-first, and forwards the line after pixel 0 like a real LED.
module ws2812_stream_decoder #(
  parameter int CNT_W = 16,
  parameter int IDX_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             din,
  input  logic [CNT_W-1:0] thr_bit,
  input  logic [CNT_W-1:0] thr_reset,
  input  logic             clear_err,
  output logic [23:0]      pixel_data,
  output logic [IDX_W-1:0] pixel_index,
  output logic             pixel_valid,
  input  logic             pixel_ready,
  output logic             frame_done,
  output logic             dout,
  output logic             err_overflow,
  output logic             err_partial
);

  // state   | meaning
  // SYNC    | after reset/disable: wait for a full reset-length low gap
  // IDLE    | between frames: wait for the first rising edge
  // HIGH    | measuring the high phase of a symbol
  // LOW     | measuring the low phase; a long enough low ends the frame
  typedef enum logic [1:0] {ST_SYNC, ST_IDLE, ST_HIGH, ST_LOW} state_t;

  state_t           state;
  logic             din_m, din_s, din_q;
  logic [CNT_W-1:0] high_cnt, low_cnt;
  logic [22:0]      shreg;
  logic [4:0]       bit_cnt;
  logic [IDX_W-1:0] frame_idx;
  logic             fwd_en;

  logic             rise, fall, bit_val, low_done, last_bit;
  logic             load, ovf_evt, part_evt;
  logic [CNT_W-1:0] high_inc, low_inc;
  logic [23:0]      shreg_nxt;

  always_comb begin
    rise      = din_s & ~din_q;
    fall      = ~din_s & din_q;
    high_inc  = (high_cnt == '1) ? high_cnt : high_cnt + 1'b1;
    low_inc   = (low_cnt == '1) ? low_cnt : low_cnt + 1'b1;
    bit_val   = (high_cnt > thr_bit);
    shreg_nxt = {shreg, bit_val};
    low_done  = (low_inc >= thr_reset);
    last_bit  = (bit_cnt == 5'd23);
    load      = 1'b0;
    ovf_evt   = 1'b0;
    part_evt  = 1'b0;
    if (enable && state == ST_HIGH && fall && last_bit) begin
      load    = ~pixel_valid | pixel_ready;
      ovf_evt = pixel_valid & ~pixel_ready;
    end
    if (enable && state == ST_LOW && !rise && low_done)
      part_evt = (bit_cnt != 5'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_SYNC;
      din_m        <= 1'b0;
      din_s        <= 1'b0;
      din_q        <= 1'b0;
      high_cnt     <= '0;
      low_cnt      <= '0;
      shreg        <= '0;
      bit_cnt      <= '0;
      frame_idx    <= '0;
      fwd_en       <= 1'b0;
      pixel_data   <= '0;
      pixel_index  <= '0;
      pixel_valid  <= 1'b0;
      frame_done   <= 1'b0;
      dout         <= 1'b0;
      err_overflow <= 1'b0;
      err_partial  <= 1'b0;
    end else begin
      din_m        <= din;
      din_s        <= din_m;
      din_q        <= din_s;
      dout         <= fwd_en & din_s;
      frame_done   <= 1'b0;
      err_overflow <= (err_overflow & ~clear_err) | ovf_evt;
      err_partial  <= (err_partial & ~clear_err) | part_evt;

      // A load on the handshake edge keeps the buffer full
      if (load) begin
        pixel_data  <= shreg_nxt;
        pixel_index <= frame_idx;
        pixel_valid <= 1'b1;
      end else if (pixel_valid && pixel_ready) begin
        pixel_valid <= 1'b0;
      end

      if (!enable) begin
        state     <= ST_SYNC;
        high_cnt  <= '0;
        low_cnt   <= '0;
        bit_cnt   <= '0;
        frame_idx <= '0;
        fwd_en    <= 1'b0;
      end else begin
        case (state)
          ST_SYNC: begin
            if (din_s) begin
              low_cnt <= '0;
            end else if (low_done) begin
              low_cnt <= '0;
              state   <= ST_IDLE;
            end else begin
              low_cnt <= low_inc;
            end
          end
          ST_IDLE: begin
            if (rise) begin
              high_cnt <= {{(CNT_W-1){1'b0}}, 1'b1};
              state    <= ST_HIGH;
            end
          end
          ST_HIGH: begin
            if (fall) begin
              shreg   <= shreg_nxt[22:0];
              low_cnt <= {{(CNT_W-1){1'b0}}, 1'b1};
              state   <= ST_LOW;
              if (last_bit) begin
                bit_cnt   <= '0;
                frame_idx <= frame_idx + 1'b1;
                if (frame_idx == '0) fwd_en <= 1'b1;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end else begin
              high_cnt <= high_inc;
            end
          end
          ST_LOW: begin
            if (rise) begin
              high_cnt <= {{(CNT_W-1){1'b0}}, 1'b1};
              state    <= ST_HIGH;
            end else if (low_done) begin
              frame_done <= 1'b1;
              frame_idx  <= '0;
              bit_cnt    <= '0;
              fwd_en     <= 1'b0;
              state      <= ST_IDLE;
            end else begin
              low_cnt <= low_inc;
            end
          end
          default: state <= ST_SYNC;
        endcase
      end
    end
  end

endmodule
